alu_shuffle_iter: RTL and testbench
===================================

# alu_shuffle_iter

Iterative perfect-shuffle engine for the advanced ALU datapath. It sits directly downstream of the combinational 32-bit shuffle/unshuffle stage and feeds that stage's output back through a result register, so a single request can apply the permutation 0–31 times. Operand, mode and count are exchanged over valid/ready handshakes on both sides. The pass count is reduced modulo the permutation period, which bounds latency.

## Interface
- No parameters; data width fixed at 32, count width fixed at 5.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  engine can accept a request
- in_data  input  32  operand
- in_mode  input  1  0 = shuffle (interleave), 1 = unshuffle (de-interleave)
- in_count  input  5  requested number of passes, 0–31
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  32  permuted result
- busy  output  1  high in RUN or DONE

## Operation
- One pass, shuffle (mode 0), for i in 0..15:
  - r[2i] = d[i]
  - r[2i+1] = d[i+16]
- One pass, unshuffle (mode 1), for i in 0..15:
  - r[i] = d[2i]
  - r[i+16] = d[2i+1]
- Shuffle maps bit position p to (2p mod 31) for p<31; bit 31 is fixed. Period is 5. Unshuffle is its exact inverse.
- Effective passes k = in_count mod 5, range 0–4. Mod-5 reduction is combinational on the 5-bit count: 0–4 map to themselves, 5 maps to 0, …, 31 maps to 1.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_data into the data register, latch in_mode, and load the remaining-pass counter with k.
  - If k==0, go to DONE; otherwise go to RUN.
- RUN:
  - Each clock, data register <= pass(data register, latched mode) and rem <= rem-1.
  - When rem==1 at the clock edge, go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1 and out_data = data register.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready=0.
- in_mode, in_count and in_data are sampled only at the accept edge. Later changes have no effect on the request in flight.
- out_data holds the data register in all states and is meaningful only while out_valid=1.
- Reset, asynchronous and taking effect at any time including mid-RUN or mid-DONE:
  - State goes to IDLE and the data register, rem and latched mode clear to 0.
  - The in-flight request is discarded and no output is produced.
  - Reset values: in_ready=1, out_valid=0, out_data=0x00000000, busy=0.

## Timing
- Accept edge is E0 (in_valid&&in_ready sampled high).
- out_valid rises after edge E0+k:
  - k=0: one cycle after accept.
  - k=4: five cycles after accept.
- out_valid stays high, with out_data stable, until the edge where out_ready=1. It drops after that edge, and in_ready rises in the same cycle.
- No accept during DONE, even if out_ready=1 in that cycle. Minimum request-to-request spacing is k+2 cycles.
- out_valid, in_ready and busy are decoded from registered state only, with no combinational path from out_ready or in_valid.
- in_valid asserted while in_ready=0 is ignored. The upstream must hold the request until accepted.

## Test plan
- Reset then idle:
  - During and after rst_n low: in_ready=1, out_valid=0, busy=0, out_data=0x00000000.
  - Asserting rst_n low mid-RUN returns these values immediately (asynchronously) and produces no output.
- Single shuffle: in_data=0x0000FFFF, mode 0, count 1, out_ready=1 → out_data=0x55555555, out_valid high two cycles after the accept edge.
- Double shuffle and mod reduction:
  - 0x0000FFFF, mode 0, count 2 → 0x33333333.
  - Same operand with count 7 → 0x33333333 with identical latency.
  - count 31 → 0x55555555.
- Unshuffle inverse and identity:
  - 0x55555555, mode 1, count 1 → 0x0000FFFF.
  - 0x12345678 with count 0 or count 5 (either mode) → 0x12345678, out_valid one cycle after accept.
- Backpressure:
  - 0x0000FFFF, mode 0, count 4, with out_ready held low 10 cycles → out_valid stays 1, out_data stays constant, in_ready stays 0, and a second in_valid is not accepted.
  - After out_ready pulses high, in_ready rises next cycle and the second request completes correctly.
- Input stability:
  - Change in_mode, in_count and in_data on the cycle after accept and during RUN → result matches the values sampled at accept.
  - Random 1000-request regression against a bit-position reference model, with random valid/ready stalls.

Source files
------------

// File: rtl/alu_shuffle_iter_if.sv
// alu_shuffle_iter_if: request and result handshake bundle for the iterative shuffle engine.
interface alu_shuffle_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_mode;
    logic [4:0]  in_count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    modport slave (
        input  in_valid, in_data, in_mode, in_count, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_mode, in_count, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/alu_shuffle_iter.sv
// alu_shuffle_iter: applies the 32-bit perfect shuffle/unshuffle (in_count mod 5) times,
// one pass per clock, through a feedback result register.
module alu_shuffle_iter (
    input  logic              clk,
    input  logic              rst_n,
    alu_shuffle_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  rem_q, rem_d;
    logic        mode_q, mode_d;
    logic [2:0]  k;
    logic [31:0] shuf, unsh;

    // The permutation has period 5, so only the residue of the count matters.
    assign k = 3'(bus.in_count % 5'd5);

    for (genvar i = 0; i < 16; i++) begin : g_perm
        assign shuf[2*i]    = data_q[i];
        assign shuf[2*i+1]  = data_q[i+16];
        assign unsh[i]      = data_q[2*i];
        assign unsh[i+16]   = data_q[2*i+1];
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                data_d  = bus.in_data;
                mode_d  = bus.in_mode;
                rem_d   = k;
                state_d = (k == 3'd0) ? DONE : RUN;
            end
            RUN: begin
                data_d  = mode_q ? unsh : shuf;
                rem_d   = rem_q - 3'd1;
                state_d = (rem_q == 3'd1) ? DONE : RUN;
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = data_q;
endmodule

// File: tb/tb_alu_shuffle_iter.sv
// tb_alu_shuffle_iter: directed and random checks of the iterative shuffle engine
// against a bit-position reference model.
module tb_alu_shuffle_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rand_rdy = 1'b0;
    logic rdy_force = 1'b1;
    logic rnd_bit = 1'b1;
    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int m_done = 0;
    int m_st = 0;
    int m_wait = 0;
    logic [31:0] m_exp = '0;

    alu_shuffle_iter_if bus ();

    alu_shuffle_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);
    assign bus.out_ready = rand_rdy ? rnd_bit : rdy_force;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Bit p moves to 2p mod 31 per shuffle (bit 31 fixed); unshuffle multiplies by 16, the inverse of 2 mod 31.
    function automatic logic [31:0] ref_perm(input logic [31:0] d, input logic m, input logic [4:0] c);
        int k, q;
        ref_perm = '0;
        k = int'(c) % 5;
        for (int p = 0; p < 32; p++) begin
            q = p;
            for (int j = 0; j < k; j++) q = (q == 31) ? 31 : (m ? (q * 16) % 31 : (q * 2) % 31);
            ref_perm[q] = d[p];
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_st = 0;
            chk("reset ctrl {in_ready,out_valid,busy}", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'h4);
            chk("reset out_data", bus.out_data, 32'h0);
        end else begin
            chk("ctrl {in_ready,out_valid,busy}", {29'd0, bus.in_ready, bus.out_valid, bus.busy},
                {29'd0, m_st == 0, m_st == 2, m_st != 0});
            if (m_st == 2) chk("model out_data", bus.out_data, m_exp);
            if (m_st == 0 && bus.in_valid) begin
                m_exp  = ref_perm(bus.in_data, bus.in_mode, bus.in_count);
                m_wait = int'(bus.in_count) % 5;
                m_st   = (m_wait == 0) ? 2 : 1;
            end else if (m_st == 1) begin
                m_wait--;
                if (m_wait == 0) m_st = 2;
            end else if (m_st == 2 && bus.out_ready) begin
                m_st = 0;
                m_done++;
            end
        end
    end

    task automatic req(input logic [31:0] d, input logic m, input logic [4:0] c,
                       input logic [31:0] exp, input int lat, input string nm);
        int n;
        bus.in_data = d; bus.in_mode = m; bus.in_count = c; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_data = ~d; bus.in_mode = ~m; bus.in_count = c + 5'd3;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1; n++;
            bus.in_data = $urandom; bus.in_count = 5'($urandom);
        end
        chk({nm, " latency"}, 32'(n), 32'(lat));
        chk(nm, bus.out_data, exp);
        n_acc++;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic [31:0] held;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 1'b0; bus.in_count = '0;
        chk("model shuffle x1", ref_perm(32'h0000FFFF, 1'b0, 5'd1), 32'h55555555);
        chk("model shuffle x2", ref_perm(32'h0000FFFF, 1'b0, 5'd2), 32'h33333333);
        chk("model unshuffle x1", ref_perm(32'h55555555, 1'b1, 5'd1), 32'h0000FFFF);
        chk("model shuffle x4", ref_perm(32'h0000FFFF, 1'b0, 5'd4), 32'h00FF00FF);
        #1;
        chk("during reset ctrl", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'h4);
        chk("during reset out_data", bus.out_data, 32'h0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after reset ctrl", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'h4);

        req(32'h0000FFFF, 1'b0, 5'd1,  32'h55555555, 1, "shuffle c1");
        req(32'h0000FFFF, 1'b0, 5'd2,  32'h33333333, 2, "shuffle c2");
        req(32'h0000FFFF, 1'b0, 5'd7,  32'h33333333, 2, "shuffle c7");
        req(32'h0000FFFF, 1'b0, 5'd31, 32'h55555555, 1, "shuffle c31");
        req(32'h55555555, 1'b1, 5'd1,  32'h0000FFFF, 1, "unshuffle c1");
        req(32'h12345678, 1'b0, 5'd0,  32'h12345678, 0, "identity c0");
        req(32'h12345678, 1'b1, 5'd5,  32'h12345678, 0, "identity c5");
        req(32'h0000FFFF, 1'b0, 5'd4,  32'h00FF00FF, 4, "shuffle c4");

        // Backpressure with a second request already waiting.
        rdy_force = 1'b0;
        bus.in_data = 32'h0000FFFF; bus.in_mode = 1'b0; bus.in_count = 5'd4; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_data = 32'h55555555; bus.in_mode = 1'b1; bus.in_count = 5'd1;
        n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp latency", 32'(n), 32'd4);
        held = bus.out_data;
        chk("bp data", held, 32'h00FF00FF);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp hold ctrl {in_ready,out_valid,busy}", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'h3);
            chk("bp hold data", bus.out_data, held);
        end
        rdy_force = 1'b1;
        @(posedge clk); #1;
        chk("bp release ctrl {in_ready,out_valid,busy}", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'h4);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp second latency", 32'(n), 32'd1);
        chk("bp second data", bus.out_data, 32'h0000FFFF);
        n_acc += 2;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN discards the request.
        bus.in_data = 32'h0000FFFF; bus.in_mode = 1'b0; bus.in_count = 5'd4; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid-run reset ctrl", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'h4);
        chk("mid-run reset out_data", bus.out_data, 32'h0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post-reset no output", {31'd0, bus.out_valid}, 32'h0);
        end

        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.in_data = $urandom; bus.in_mode = 1'($urandom); bus.in_count = 5'($urandom);
            bus.in_valid = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
            if (n == 100) chk("random accept timeout", 32'(n), 32'd0);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_data = $urandom; bus.in_count = 5'($urandom);
            n_acc++;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        n = 0;
        while (bus.busy && n < 200) begin @(posedge clk); #1; n++; end
        chk("drain busy", {31'd0, bus.busy}, 32'h0);
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        chk("results delivered", 32'(m_done), 32'(n_acc));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
